rvb_clmul_arbiter: RTL
======================

Name: rvb_clmul_arbiter

Overview:
- Shares one multi-cycle carry-less multiplier unit (4-iteration, 8 bits per iteration) between NUM_REQ requesters, e.g. two bitmanip issue ports.
- Round-robin grant, valid/ready handshakes on both sides, one operation in flight at a time.
- Holds each result until the owning requester accepts it.
- Adds a hang watchdog and a completed-operation counter.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT, 15, maximum WAIT cycles before the watchdog fires (must be ≥ 6).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle.
- req_rs1  in  32*NUM_REQ  operand 1; slice i belongs to requester i.
- req_rs2  in  32*NUM_REQ  operand 2.
- req_h  in  NUM_REQ  1 = CLMULH, 0 = CLMUL.
- resp_valid  out  NUM_REQ  result valid for requester i.
- resp_ready  in  NUM_REQ  requester i accepts the result.
- resp_rd  out  32  result data, shared by all requesters; qualified by resp_valid.
- resp_err  out  1  result was produced by the watchdog, not the unit.
- u_din_ready  in  1  unit accepts operands.
- u_rs1, u_rs2  out  32  operands to the unit.
- u_op_clmul, u_op_clmulh  out  1  unit op strobes.
- u_dout_valid  in  1  unit result pulse.
- u_dout_rd  in  32  unit result.
- err_timeout  out  1  sticky watchdog flag.
- ops_done  out  32  count of completed response handshakes.

Behaviour:
- Async reset (reset=0):
  - state=IDLE, rr pointer=0, operand/result regs=0.
  - All outputs 0: req_ready, resp_valid, resp_err, u_op_*, err_timeout, ops_done, watchdog counter.
  - Reset mid-operation abandons the op with no response. The unit shares the same reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the winner: the first set bit searching from rr+1 (mod NUM_REQ) upward.
  - Assert req_ready[winner] combinationally in this cycle only.
  - Latch rs1, rs2, h and the grant index; go to ISSUE.
  - No req_valid: stay in IDLE, req_ready=0.
- ISSUE:
  - Drive u_rs1/u_rs2 from the latched regs; u_op_clmulh=h, u_op_clmul=!h.
  - When u_din_ready=1, the unit samples at this edge: clear the watchdog counter, go to WAIT.
  - Otherwise hold all drives.
- WAIT:
  - u_op_* = 0, which keeps the unit from re-accepting. The watchdog counter increments every cycle.
  - On u_dout_valid: capture u_dout_rd, resp_err=0, go to RESP.
  - If the counter reaches TIMEOUT with no u_dout_valid: result=0, resp_err=1, set err_timeout, go to RESP.
  - If u_dout_valid arrives in the same cycle the counter hits TIMEOUT, the unit result wins.
- RESP:
  - resp_valid[grant]=1, all other bits 0; resp_rd/resp_err are stable while held.
  - On resp_ready[grant]: ops_done+1 (wraps at 2^32), rr=grant, go to IDLE.
  - resp_ready on other bits is ignored.
- Latency: the RESP state is entered 7 cycles after the IDLE accept edge when the unit is idle (1 ISSUE + 4 unit iterations + 1 completion + capture).
  - IDLE→IDLE minimum turnaround is 8 cycles, with resp_ready held high.
  - There is no back-to-back accept: a new request is granted only from IDLE.
- Requester rules:
  - A requester must hold req_valid and its operands stable until req_ready.
  - Deasserting req_valid before grant withdraws the request; no error.
- Fairness:
  - A requester that keeps req_valid high is served within NUM_REQ grants.
  - With a single active requester it is re-granted every turnaround.
- err_timeout is sticky until reset.

Decomposition:
- Shared bitmanip package holds:
  - FSM state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Op select constants: CLMUL=0, CLMULH=1.
  - Default TIMEOUT.
- One natural sub-module: rvb_rr_pick, a combinational round-robin priority picker (req vector + pointer → one-hot grant + index). It is reusable by other shared bitmanip units.

Test Plan:
- Req0 only: rs1=0x00000003, rs2=0x00000005, h=0 → resp_valid[0] exactly 7 cycles after accept, resp_rd=0x0000000F, resp_err=0, ops_done=1.
- Req1 only: rs1=0x80000000, rs2=0x80000000, h=1 → resp_rd=0x40000000 on resp_valid[1], u_op_clmulh=1 during ISSUE only.
- Both valid every cycle after reset, with distinct operands → grants alternate 1,0,1,0 (rr starts at 0); each resp_rd matches its own requester's operands.
- Hold resp_ready[0]=0 for 20 cycles in RESP → resp_valid/resp_rd stable, no new req_ready; release → IDLE next cycle, ops_done increments once.
- Tie u_dout_valid=0 → after TIMEOUT cycles in WAIT: resp_valid for the grantee, resp_rd=0, resp_err=1, err_timeout stays 1 until reset.
- Assert reset in the middle of WAIT → all outputs 0 immediately (async); after release, a fresh request completes normally with correct result.

Source files
------------

// File: rtl/rvb_clmul_arbiter_pkg.sv
// Shared bitmanip definitions: arbiter FSM encoding, op select values and
// the default watchdog limit.
package rvb_clmul_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic OP_CLMUL  = 1'b0;
   localparam logic OP_CLMULH = 1'b1;

   localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rvb_rr_pick.sv
// Combinational round-robin picker: the first set request bit searching
// upward from ptr+1 (wrapping) wins; returns a one-hot grant and its index.
module rvb_rr_pick #(
   parameter int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] idx;

   // NOTE: every combinational output gets a default before the search so
   // no path through the loop leaves a value unassigned (no latch).
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/rvb_clmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle carry-less multiplier between
// NUM_REQ requesters, with a hang watchdog and a completed-op counter.
module rvb_clmul_arbiter
   import rvb_clmul_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_rs1,
   input  logic [32*NUM_REQ-1:0] req_rs2,
   input  logic [NUM_REQ-1:0]    req_h,
   output logic [NUM_REQ-1:0]    resp_valid,
   input  logic [NUM_REQ-1:0]    resp_ready,
   output logic [31:0]           resp_rd,
   output logic                  resp_err,
   input  logic                  u_din_ready,
   output logic [31:0]           u_rs1,
   output logic [31:0]           u_rs2,
   output logic                  u_op_clmul,
   output logic                  u_op_clmulh,
   input  logic                  u_dout_valid,
   input  logic [31:0]           u_dout_rd,
   output logic                  err_timeout,
   output logic [31:0]           ops_done
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   arb_state_t         state, state_nxt;
   logic [IDX_W-1:0]   rr_q, grant_q;
   logic [31:0]        rs1_q, rs2_q, result_q, ops_q;
   logic               h_q, err_q, err_timeout_q;
   logic [WD_W-1:0]    wd_q;
   logic               wd_expired;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   logic [31:0]        rs1_arr [NUM_REQ];
   logic [31:0]        rs2_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign rs1_arr[i] = req_rs1[32*i +: 32];
      assign rs2_arr[i] = req_rs2[32*i +: 32];
   end

   rvb_rr_pick #(.N(NUM_REQ)) u_pick (
      .req       (req_valid),
      .ptr       (rr_q),
      .grant     (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   // The watchdog fires on the TIMEOUT-th WAIT cycle; a same-cycle unit result wins.
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      req_ready   = '0;
      resp_valid  = '0;
      u_op_clmul  = 1'b0;
      u_op_clmulh = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               req_ready = pick_oh;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            u_op_clmulh = (h_q == OP_CLMULH);
            u_op_clmul  = (h_q == OP_CLMUL);
            if (u_din_ready) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (u_dout_valid || wd_expired) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         rr_q          <= '0;
         grant_q       <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         h_q           <= OP_CLMUL;
         result_q      <= '0;
         err_q         <= 1'b0;
         err_timeout_q <= 1'b0;
         ops_q         <= '0;
         wd_q          <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  rs1_q   <= rs1_arr[pick_idx];
                  rs2_q   <= rs2_arr[pick_idx];
                  h_q     <= req_h[pick_idx];
                  grant_q <= pick_idx;
               end
            end
            ST_ISSUE: begin
               if (u_din_ready) wd_q <= '0;
            end
            ST_WAIT: begin
               wd_q <= wd_q + 1'b1;
               if (u_dout_valid) begin
                  result_q <= u_dout_rd;
                  err_q    <= 1'b0;
               end else if (wd_expired) begin
                  result_q      <= '0;
                  err_q         <= 1'b1;
                  err_timeout_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready[grant_q]) begin
                  ops_q <= ops_q + 32'd1;
                  rr_q  <= grant_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_rd     = result_q;
   assign resp_err    = (state == ST_RESP) && err_q;
   assign u_rs1       = rs1_q;
   assign u_rs2       = rs2_q;
   assign err_timeout = err_timeout_q;
   assign ops_done    = ops_q;

endmodule
